branch_steer_ctrl: RTL and testbench
====================================

# branch_steer_ctrl

Fetch-steering controller for the pipelined MIPS datapath: keeps a 2-bit saturating direction predictor indexed by fetch PC and drives the fetch stage's `takebranch` input. Detects branch mispredictions resolved in MEM. Issues the corrective PC-source select and pipeline flush, holding the redirect until fetch accepts it on `ihit`. Sits beside the hazard unit, between the EX/MEM latch and instruction fetch.

## Interface
Parameters:
- `INDEX_BITS`, 6: predictor index width; table has 2^INDEX_BITS entries, indexed by `pc[INDEX_BITS+1:2]`.
- `CTR_INIT`, 2'b01: reset value of every counter (weakly not-taken).

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `pc_if` in 32: current fetch PC.
- `ihit` in 1: instruction fetch completes this cycle.
- `br_valid_mem` in 1: a beq/bne is in MEM this cycle.
- `br_taken_mem` in 1: resolved outcome of that branch.
- `br_pred_mem` in 1: fetch's `branched` flag carried down the pipeline with that branch.
- `pc_mem` in 32: PC of the branch in MEM.
- `mem_stall` in 1: MEM latch held this cycle (dcache wait).
- `takebranch` out 1: predict-taken for `pc_if`; fetch combines it with its BTB hit.
- `redirect` out 1: corrective PC select is valid.
- `redirect_src` out 3: 3'b010 = branch target, 3'b100 = `pc_mem`+4, 3'b000 otherwise.
- `flush` out 1: squash IF/ID, ID/EX and EX/MEM.
- `br_count` out 16: resolved branches; present only with stats.
- `mispred_count` out 16: mispredictions; present only with stats.

## Operation
- Counter table: 2^INDEX_BITS x 2-bit registers. Prediction = `ctr[1]`.
- `takebranch` = `table[pc_if[INDEX_BITS+1:2]][1]` when state IDLE; forced 0 in HOLD.
- Resolution event `res` = `br_valid_mem && !mem_stall && state==IDLE`. Only an event with `mem_stall` low counts, so each branch updates once.
- On `res`: counter at `pc_mem[INDEX_BITS+1:2]` increments if taken, else decrements. Saturates at 2'b11 and 2'b00.
- Mispredict `mp` = `res && (br_taken_mem != br_pred_mem)`.
  - Source = 3'b010 if `br_taken_mem` (predicted not-taken, actually taken).
  - Source = 3'b100 otherwise (predicted taken, actually not-taken).
- FSM, two states:
  - IDLE: on `mp`, `redirect`=1, `flush`=1 and `redirect_src`=computed source, all combinationally. If `ihit` is also 1, stay IDLE; else latch source into `held_src` and go to HOLD.
  - HOLD: `redirect`=1, `flush`=1, `redirect_src`=`held_src`. Branch events are ignored. On `ihit`, return to IDLE.
- No `mp` in IDLE: `redirect`=0, `flush`=0, `redirect_src`=3'b000.

## Timing
- Reset (async, `nRST` low): every counter = CTR_INIT, state = IDLE, `held_src` = 0, stats counters = 0.
  - Resulting outputs: `takebranch` = CTR_INIT[1], `redirect`=0, `flush`=0, `redirect_src`=0, counts 0.
  - Reset asserted mid-HOLD abandons the redirect.
- `takebranch` is combinational from `pc_if` with zero latency.
- Table update takes effect at the next rising edge. A same-cycle read of the index being written returns the old value.
- Redirect latency: asserted in the same cycle `mp` is seen. Held for N+1 cycles when `ihit` arrives N cycles later.
- Index aliasing, where PCs 2^(INDEX_BITS+2) bytes apart share an entry, is permitted and not detected.
- `mem_stall` high with `br_valid_mem` high: no update, no redirect. Evaluation happens on the cycle the stall drops.

## Configuration
- `BP_STATS_EN` defined:
  - `br_count` increments on each `res`.
  - `mispred_count` increments on each `mp`.
  - Both saturate at 16'hFFFF.
- Not defined: both ports are tied to 16'h0000 and no counter registers exist. Prediction and redirect behaviour are identical either way.

## Test plan
- Reset, then `pc_if`=0x40 -> `takebranch`=0, all counters read 2'b01, `redirect`=0.
- Three taken resolutions at `pc_mem`=0x40, each with `br_pred_mem` matching the counter -> counter goes 01->10->11->11 (saturates); `takebranch`=1 for `pc_if`=0x40. The first resolution mispredicts: `redirect_src`=3'b010.
- Counter at 2'b11, `br_pred_mem`=1, `br_taken_mem`=0, `ihit`=0 for 3 cycles, then 1 -> `redirect`/`flush` high for 4 cycles with `redirect_src`=3'b100 throughout; counter becomes 2'b10.
- `br_valid_mem`=1 with `mem_stall`=1 for 5 cycles, then 0 -> exactly one counter update and one evaluation; `br_count` +1 with stats enabled.
- Aliasing with `pc_if`=0x140 while `pc_mem`=0x40 is updated in the same cycle -> `takebranch` shows the pre-update value; the new value appears next cycle.
- Assert `nRST` low during HOLD -> `redirect`=0 immediately; after release, state is IDLE and counters are CTR_INIT.

Source files
------------

// File: rtl/branch_steer_ctrl.sv
// branch_steer_ctrl: 2-bit direction predictor and MEM-stage mispredict redirect.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_steer_ctrl #(
  parameter int          INDEX_BITS = 6,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_if,
  input  logic        ihit,
  input  logic        br_valid_mem,
  input  logic        br_taken_mem,
  input  logic        br_pred_mem,
  input  logic [31:0] pc_mem,
  input  logic        mem_stall,
  output logic        takebranch,
  output logic        redirect,
  output logic [2:0]  redirect_src,
  output logic        flush,
  output logic [15:0] br_count,
  output logic [15:0] mispred_count
);

  localparam int N = 1 << INDEX_BITS;

  localparam logic [2:0] SRC_TGT = 3'b010;
  localparam logic [2:0] SRC_SEQ = 3'b100;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              held_src_q, held_src_d;
  logic [1:0]              ctr_q [N];
  logic [1:0]              ctr_d [N];
  logic [INDEX_BITS-1:0]   rd_idx;
  logic [INDEX_BITS-1:0]   wr_idx;
  logic                    res;
  logic                    mp;
  logic [2:0]              mp_src;
  logic                    unused_pc;

  assign rd_idx = pc_if[INDEX_BITS+1:2];
  assign wr_idx = pc_mem[INDEX_BITS+1:2];

  assign unused_pc = ^{pc_if[31:INDEX_BITS+2], pc_if[1:0],
                       pc_mem[31:INDEX_BITS+2], pc_mem[1:0]};

  assign res    = br_valid_mem && !mem_stall && (state_q == IDLE);
  assign mp     = res && (br_taken_mem != br_pred_mem);
  assign mp_src = br_taken_mem ? SRC_TGT : SRC_SEQ;

  assign takebranch = (state_q == IDLE) && ctr_q[rd_idx][1];

  // Saturating counter update for the resolving branch's entry.
  always_comb begin
    ctr_d = ctr_q;
    if (res) begin
      if (br_taken_mem) begin
        if (ctr_q[wr_idx] != 2'b11)
          ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
      end else begin
        if (ctr_q[wr_idx] != 2'b00)
          ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
      end
    end
  end

  // Counter table registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++)
        ctr_q[i] <= CTR_INIT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Redirect FSM: next state, held source and redirect outputs.
  always_comb begin
    state_d      = state_q;
    held_src_d   = held_src_q;
    redirect     = 1'b0;
    flush        = 1'b0;
    redirect_src = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (mp) begin
          redirect     = 1'b1;
          flush        = 1'b1;
          redirect_src = mp_src;
          if (!ihit) begin
            held_src_d = mp_src;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        redirect     = 1'b1;
        flush        = 1'b1;
        redirect_src = held_src_q;
        if (ihit)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      held_src_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      held_src_q <= held_src_d;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] mp_cnt_q, mp_cnt_d;

  // Saturating resolution and mispredict counts.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (res && br_cnt_q != 16'hFFFF)
      br_cnt_d = br_cnt_q + 16'd1;
    if (mp && mp_cnt_q != 16'hFFFF)
      mp_cnt_d = mp_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_cnt_q <= 16'h0000;
      mp_cnt_q <= 16'h0000;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mp_cnt_q;
`else
  assign br_count      = 16'h0000;
  assign mispred_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_steer_ctrl.sv
// tb_branch_steer_ctrl: directed scenarios plus random traffic
// checked against a behavioural predictor/redirect model.
module tb_branch_steer_ctrl;

  localparam int IB = 6;
  localparam int NE = 1 << IB;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc_if;
  logic        ihit;
  logic        br_valid_mem;
  logic        br_taken_mem;
  logic        br_pred_mem;
  logic [31:0] pc_mem;
  logic        mem_stall;
  logic        takebranch;
  logic        redirect;
  logic [2:0]  redirect_src;
  logic        flush;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  int       ctr [NE];
  bit       pend;
  bit [2:0] psrc;
  int       nbr;
  int       nmp;

  bit        e_tb, e_rd, e_fl;
  bit [2:0]  e_src;
  bit [15:0] e_bc, e_mc;

  branch_steer_ctrl dut (
    .CLK(CLK), .nRST(nRST), .pc_if(pc_if), .ihit(ihit),
    .br_valid_mem(br_valid_mem), .br_taken_mem(br_taken_mem),
    .br_pred_mem(br_pred_mem), .pc_mem(pc_mem),
    .mem_stall(mem_stall), .takebranch(takebranch),
    .redirect(redirect), .redirect_src(redirect_src),
    .flush(flush), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) ctr[i] = 1;
    pend = 0;
    psrc = 3'b000;
    nbr  = 0;
    nmp  = 0;
  endfunction

  function automatic void model_out();
    int k;
    k     = int'(pc_if[IB+1:2]);
    e_tb  = !pend && (ctr[k] >= 2);
    e_rd  = 0;
    e_src = 3'b000;
    if (pend) begin
      e_rd  = 1;
      e_src = psrc;
    end else if (br_valid_mem && !mem_stall
                 && br_taken_mem != br_pred_mem) begin
      e_rd  = 1;
      e_src = br_taken_mem ? 3'b010 : 3'b100;
    end
    e_fl = e_rd;
`ifdef BP_STATS_EN
    e_bc = 16'(nbr);
    e_mc = 16'(nmp);
`else
    e_bc = 16'h0;
    e_mc = 16'h0;
`endif
  endfunction

  function automatic void model_step();
    int k;
    if (pend) begin
      if (ihit) pend = 0;
    end else if (br_valid_mem && !mem_stall) begin
      k = int'(pc_mem[IB+1:2]);
      if (br_taken_mem) ctr[k] = (ctr[k] == 3) ? 3 : ctr[k] + 1;
      else              ctr[k] = (ctr[k] == 0) ? 0 : ctr[k] - 1;
      if (nbr < 65535) nbr++;
      if (br_taken_mem != br_pred_mem) begin
        if (nmp < 65535) nmp++;
        if (!ihit) begin
          pend = 1;
          psrc = br_taken_mem ? 3'b010 : 3'b100;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    ihit = 1; br_valid_mem = 0; br_taken_mem = 0;
    br_pred_mem = 0; mem_stall = 0;
  endtask

  task automatic test_reset();
    nRST = 0; pc_if = 32'h40; pc_mem = 32'h0; idle_in();
    model_reset();
    #3;
    n_cmp++;
    if (takebranch !== 1'b0 || redirect !== 1'b0 || flush !== 1'b0
        || redirect_src !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs: tb=%b rd=%b fl=%b src=%b want 0/0/0/000",
               takebranch, redirect, flush, redirect_src);
    end
    n_cmp++;
    if (br_count !== 16'h0 || mispred_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_counts: br=%h mp=%h want 0/0",
               br_count, mispred_count);
    end
    @(negedge CLK);
    nRST = 1;
    for (int i = 0; i < NE; i++) begin
      pc_if = 32'(i << 2);
      #1;
      n_cmp++;
      if (takebranch !== 1'b0) begin
        n_err++;
        $display("FAIL reset_table[%0d]: tb=%b want 0", i, takebranch);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_saturate();
    bit [2:0] want_src [3];
    want_src[0] = 3'b010; want_src[1] = 3'b000; want_src[2] = 3'b000;
    pc_if = 32'h40; pc_mem = 32'h40; idle_in();
    for (int n = 0; n < 3; n++) begin
      br_valid_mem = 1; br_taken_mem = 1;
      br_pred_mem  = (n != 0);
      #1;
      n_cmp++;
      if (redirect_src !== want_src[n] || redirect !== (n == 0)) begin
        n_err++;
        $display("FAIL sat_res%0d: rd=%b src=%b want %b/%b",
                 n, redirect, redirect_src, n == 0, want_src[n]);
      end
      tick();
    end
    br_valid_mem = 0;
    #1;
    n_cmp++;
    if (takebranch !== 1'b1 || ctr[16] != 3) begin
      n_err++;
      $display("FAIL sat_pred: tb=%b model_ctr=%0d want 1/3",
               takebranch, ctr[16]);
    end
    tick();
  endtask

  task automatic test_hold();
    pc_if = 32'h40; pc_mem = 32'h40; idle_in();
    br_valid_mem = 1; br_taken_mem = 0; br_pred_mem = 1; ihit = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) br_valid_mem = (c == 4) ? 0 : 1;
      ihit = (c >= 3);
      #1;
      n_cmp++;
      if (redirect !== (c < 4) || flush !== (c < 4)
          || redirect_src !== ((c < 4) ? 3'b100 : 3'b000)) begin
        n_err++;
        $display("FAIL hold_c%0d: rd=%b fl=%b src=%b want %b/%b/%b",
                 c, redirect, flush, redirect_src, c < 4, c < 4,
                 (c < 4) ? 3'b100 : 3'b000);
      end
      if (c >= 1 && c < 4) begin
        n_cmp++;
        if (takebranch !== 1'b0) begin
          n_err++;
          $display("FAIL hold_tb_c%0d: tb=%b want 0", c, takebranch);
        end
      end
      tick();
    end
    br_valid_mem = 0;
    #1;
    n_cmp++;
    if (takebranch !== 1'b1 || ctr[16] != 2) begin
      n_err++;
      $display("FAIL hold_ctr: tb=%b model_ctr=%0d want 1/2",
               takebranch, ctr[16]);
    end
  endtask

  task automatic test_stall();
    int bc0;
    bc0 = nbr;
    pc_if = 32'h80; pc_mem = 32'h80; idle_in();
    br_valid_mem = 1; br_taken_mem = 1; br_pred_mem = 0; mem_stall = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (redirect !== 1'b0 || takebranch !== 1'b0) begin
        n_err++;
        $display("FAIL stall_c%0d: rd=%b tb=%b want 0/0",
                 c, redirect, takebranch);
      end
      tick();
    end
    mem_stall = 0;
    #1;
    n_cmp++;
    if (redirect !== 1'b1 || redirect_src !== 3'b010) begin
      n_err++;
      $display("FAIL stall_drop: rd=%b src=%b want 1/010",
               redirect, redirect_src);
    end
    tick();
    br_valid_mem = 0;
    #1;
    n_cmp++;
    if (takebranch !== 1'b1 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after: tb=%b rd=%b want 1/0",
               takebranch, redirect);
    end
`ifdef BP_STATS_EN
    n_cmp++;
    if (br_count !== 16'(bc0 + 1)) begin
      n_err++;
      $display("FAIL stall_brcount: got %0d want %0d", br_count, bc0 + 1);
    end
`else
    n_cmp++;
    if (br_count !== 16'h0 || bc0 + 1 != nbr) begin
      n_err++;
      $display("FAIL stall_brcount: got %0d want 0", br_count);
    end
`endif
    tick();
  endtask

  task automatic test_alias();
    pc_if = 32'h140; pc_mem = 32'h40; idle_in();
    br_valid_mem = 1; br_taken_mem = 0; br_pred_mem = 0;
    #1;
    n_cmp++;
    if (takebranch !== 1'b1) begin
      n_err++;
      $display("FAIL alias_old: tb=%b want 1", takebranch);
    end
    tick();
    br_valid_mem = 0;
    #1;
    n_cmp++;
    if (takebranch !== 1'b0) begin
      n_err++;
      $display("FAIL alias_new: tb=%b want 0", takebranch);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      pc_if        = 32'($urandom_range(0, 127) << 2);
      pc_mem       = 32'($urandom_range(0, 127) << 2);
      br_valid_mem = ($urandom_range(0, 99) < 60);
      br_taken_mem = $urandom_range(0, 1);
      br_pred_mem  = $urandom_range(0, 1);
      mem_stall    = ($urandom_range(0, 99) < 25);
      ihit         = ($urandom_range(0, 99) < 50);
      #1;
      model_out();
      n_cmp++;
      if (takebranch !== e_tb || redirect !== e_rd || flush !== e_fl
          || redirect_src !== e_src || br_count !== e_bc
          || mispred_count !== e_mc) begin
        n_err++;
        $display("FAIL rand_c%0d: got tb=%b rd=%b fl=%b src=%b bc=%0d mc=%0d want %b/%b/%b/%b/%0d/%0d",
                 c, takebranch, redirect, flush, redirect_src, br_count,
                 mispred_count, e_tb, e_rd, e_fl, e_src, e_bc, e_mc);
      end
      tick();
    end
    idle_in();
    while (pend) tick();
  endtask

  task automatic test_reset_hold();
    pc_if = 32'h40; pc_mem = 32'h40; idle_in();
    br_valid_mem = 1;
    br_taken_mem = (ctr[16] < 2);
    br_pred_mem  = (ctr[16] >= 2);
    ihit = 0;
    tick();
    br_valid_mem = 0;
    #1;
    n_cmp++;
    if (redirect !== 1'b1) begin
      n_err++;
      $display("FAIL rsthold_pre: rd=%b want 1", redirect);
    end
    nRST = 0;
    model_reset();
    #1;
    n_cmp++;
    if (redirect !== 1'b0 || flush !== 1'b0 || redirect_src !== 3'b000
        || takebranch !== 1'b0) begin
      n_err++;
      $display("FAIL rsthold_async: rd=%b fl=%b src=%b tb=%b want 0/0/000/0",
               redirect, flush, redirect_src, takebranch);
    end
    @(negedge CLK);
    nRST = 1;
    tick();
    for (int i = 0; i < NE; i++) begin
      pc_if = 32'(i << 2);
      #1;
      n_cmp++;
      if (takebranch !== 1'b0 || redirect !== 1'b0) begin
        n_err++;
        $display("FAIL rsthold_table[%0d]: tb=%b rd=%b want 0/0",
                 i, takebranch, redirect);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_hold();
    test_stall();
    test_alias();
    test_random();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
